// File: rtl/round_robin_req_client.sv
// rtl/round_robin_req_client.sv - requester-side agent for a round-robin bus arbiter
//
// Each channel keeps its own queue of pending jobs. While work is pending it
// requests the bus. Once granted, it holds req for XFER_CYCLES cycles. It then
// drops req for exactly one cycle so the arbiter can rotate to another channel.
// The block also watches the grant vector and flags any grant that no
// well-behaved arbiter would produce.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous reset, active low
//   job_push   in   N   per-channel one-cycle pulse: enqueue one job
//   grant      in   N   one-hot grant from the arbiter
//   req        out  N   registered request to the arbiter
//   done       out  N   one-cycle pulse: channel finished a transfer
//   busy       out  N   channel is currently transferring
//   overflow   out  1   sticky: push arrived at a full pending counter
//   proto_err  out  1   sticky: illegal grant observed

module round_robin_req_client #(
   parameter int N           = 4,
   parameter int XFER_CYCLES = 3,
   parameter int CNT_W       = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] job_push,
   input  logic [N-1:0] grant,
   output logic [N-1:0] req,
   output logic [N-1:0] done,
   output logic [N-1:0] busy,
   output logic         overflow,
   output logic         proto_err
);

   localparam int XW = (XFER_CYCLES > 1) ? $clog2(XFER_CYCLES) : 1;
   localparam logic [XW-1:0]    XLOAD   = XW'(XFER_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      XFER = 2'd2,
      REL  = 2'd3
   } state_t;

   logic [N-1:0] ovf_hit;
   logic [N-1:0] err_hit;
   logic         multi_grant;

   assign multi_grant = ($countones(grant) > 1);

   genvar i;
   generate
      for (i = 0; i < N; i++) begin : g_ch
         state_t           state, state_nx;
         logic [XW-1:0]    xcnt, xcnt_nx;
         logic [CNT_W-1:0] cnt, cnt_nx;
         logic             fin;
         logic             ovf_l;
         logic             req_q, busy_q, done_q;

         // Transfer sequencing
         always_comb begin
            state_nx = state;
            xcnt_nx  = xcnt;
            fin      = 1'b0;
            case (state)
               IDLE: begin
                  if (cnt != '0) state_nx = REQ;
               end
               REQ: begin
                  if (grant[i]) begin
                     state_nx = XFER;
                     xcnt_nx  = XLOAD;
                  end
               end
               XFER: begin
                  // Runs to completion even if the grant disappears;
                  // that case is only reported through proto_err.
                  if (xcnt == '0) begin
                     state_nx = REL;
                     fin      = 1'b1;
                  end else begin
                     xcnt_nx = xcnt - XW'(1);
                  end
               end
               REL: begin
                  // Going straight back to REQ keeps the release gap at one cycle.
                  state_nx = (cnt != '0) ? REQ : IDLE;
               end
               default: state_nx = IDLE;
            endcase
         end

         // Pending job counter. A push coinciding with a completion cancels out.
         always_comb begin
            cnt_nx = cnt;
            ovf_l  = 1'b0;
            if (job_push[i] && !fin) begin
               if (cnt == CNT_MAX) ovf_l  = 1'b1;
               else                cnt_nx = cnt + CNT_W'(1);
            end else if (!job_push[i] && fin) begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end

         always_ff @(posedge clk) begin
            if (!rst) begin
               state  <= IDLE;
               xcnt   <= '0;
               cnt    <= '0;
               req_q  <= 1'b0;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end else begin
               state  <= state_nx;
               xcnt   <= xcnt_nx;
               cnt    <= cnt_nx;
               req_q  <= (state_nx == REQ) || (state_nx == XFER);
               busy_q <= (state_nx == XFER);
               done_q <= fin;
            end
         end

         assign req[i]     = req_q;
         assign busy[i]    = busy_q;
         assign done[i]    = done_q;
         assign ovf_hit[i] = ovf_l;
         assign err_hit[i] = (grant[i] && ((state == IDLE) || (state == REL))) ||
                             (!grant[i] && (state == XFER));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         overflow  <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         if (|ovf_hit)                  overflow  <= 1'b1;
         if (multi_grant || (|err_hit)) proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_round_robin_req_client.sv
// tb/tb_round_robin_req_client.sv - self-checking bench for round_robin_req_client

module tb_round_robin_req_client;

   localparam int N    = 4;
   localparam int XC   = 3;
   localparam int CW   = 3;
   localparam int CMAX = (1 << CW) - 1;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] job_push;
   logic [N-1:0] grant;
   logic [N-1:0] req;
   logic [N-1:0] done;
   logic [N-1:0] busy;
   logic         overflow;
   logic         proto_err;

   always #5 clk = ~clk;

   round_robin_req_client #(.N(N), .XFER_CYCLES(XC), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .job_push  (job_push),
      .grant     (grant),
      .req       (req),
      .done      (done),
      .busy      (busy),
      .overflow  (overflow),
      .proto_err (proto_err)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: jobs waiting, transfer cycles left, and whether the
   // channel is asking for the bus.
   int           pend [N];
   int           left [N];
   logic [N-1:0] req_m, done_m, busy_m;
   logic         ovf_m, perr_m;
   int           done_q[$];

   // Arbiter model used as stimulus
   int           arb_mode = 0;
   logic [N-1:0] grant_force = '0;
   int           owner = -1;
   int           last  = N - 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      logic [N-1:0] nreq;
      if (!rst) begin
         for (int c = 0; c < N; c++) begin
            pend[c] = 0;
            left[c] = 0;
         end
         req_m = '0; done_m = '0; busy_m = '0; ovf_m = 1'b0; perr_m = 1'b0;
         return;
      end
      nreq = '0;
      if ($countones(grant) > 1) perr_m = 1'b1;
      for (int c = 0; c < N; c++) begin
         bit fin;
         int pold;
         pold = pend[c];
         fin  = (left[c] == 1);
         if (grant[c] && !req_m[c]) perr_m = 1'b1;
         if (left[c] > 0 && !grant[c]) perr_m = 1'b1;
         done_m[c] = fin;
         if (fin) done_q.push_back(c);
         if (left[c] > 0) left[c]--;
         else if (req_m[c] && grant[c]) left[c] = XC;
         if (job_push[c] && !fin) begin
            if (pend[c] == CMAX) ovf_m = 1'b1;
            else pend[c]++;
         end else if (!job_push[c] && fin) begin
            pend[c]--;
         end
         if (fin) nreq[c] = 1'b0;
         else if (left[c] > 0 || req_m[c]) nreq[c] = 1'b1;
         else nreq[c] = (pold != 0);
         busy_m[c] = (left[c] > 0);
      end
      req_m = nreq;
   endtask

   task automatic drive_grant();
      if (arb_mode == 1) begin
         grant = grant_force;
      end else begin
         if (owner >= 0 && !req_m[owner]) owner = -1;
         if (owner < 0) begin
            for (int k = 1; k <= N; k++) begin
               int c;
               c = (last + k) % N;
               if (req_m[c]) begin
                  owner = c;
                  last  = c;
                  break;
               end
            end
         end
         grant = (owner >= 0) ? N'(1 << owner) : '0;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("req",       32'(req),       32'(req_m));
      check("done",      32'(done),      32'(done_m));
      check("busy",      32'(busy),      32'(busy_m));
      check("overflow",  32'(overflow),  32'(ovf_m));
      check("proto_err", 32'(proto_err), 32'(perr_m));
      job_push = '0;
      drive_grant();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      cycle();
      cycle();
      rst = 1'b1;
   endtask

   initial begin
      int n_hi, n_done, lows, plows, k;
      bit seen;

      rst = 1'b1; job_push = '0; grant = '0;
      req_m = '0; done_m = '0; busy_m = '0; ovf_m = 1'b0; perr_m = 1'b0;
      for (int c = 0; c < N; c++) begin pend[c] = 0; left[c] = 0; end

      // Reset with pushes active
      rst = 1'b0;
      job_push = '1; cycle();
      job_push = '1; cycle();
      rst = 1'b1;
      cycle();
      check("t1_req",  32'(req),  32'(0));
      check("t1_done", 32'(done), 32'(0));
      check("t1_flags", 32'({overflow, proto_err}), 32'(0));

      // Single job on ch0
      job_push = 4'b0001; cycle();
      n_hi = 0; n_done = 0;
      for (int t = 0; t < 20; t++) begin
         cycle();
         if (req[0])  n_hi++;
         if (done[0]) n_done++;
      end
      check("t2_req_cycles", n_hi, 1 + XC);
      check("t2_done_cnt",   n_done, 1);
      check("t2_req_end",    32'(req[0]), 32'(0));

      // Back-to-back on ch2
      job_push = 4'b0100; cycle();
      job_push = 4'b0100; cycle();
      n_done = 0; lows = 0; plows = 0; seen = 0;
      for (int t = 0; t < 30; t++) begin
         cycle();
         if (done[2]) n_done++;
         if (req[2]) begin
            if (seen) lows += plows;
            plows = 0;
            seen  = 1;
         end else if (seen) begin
            plows++;
         end
      end
      check("t3_done_cnt", n_done, 2);
      check("t3_gap",      lows, 1);

      // Round-robin rotation across all channels
      owner = -1; last = N - 1;
      done_q.delete();
      job_push = '1; cycle();
      for (int t = 0; t < 40; t++) cycle();
      check("t4_done_len", done_q.size(), 4);
      for (int c = 0; c < 4; c++)
         check($sformatf("t4_order%0d", c), (c < done_q.size()) ? done_q[c] : -1, c);
      check("t4_perr", 32'(proto_err), 32'(0));

      // Overflow on ch1 with no grant
      arb_mode = 1; grant_force = '0;
      for (int t = 0; t < 8; t++) begin
         job_push = 4'b0010;
         cycle();
      end
      cycle();
      check("t5_overflow", 32'(overflow), 32'(1));
      arb_mode = 0;
      n_done = 0;
      for (int t = 0; t < 50; t++) begin
         cycle();
         if (done[1]) n_done++;
      end
      check("t5_done_cnt", n_done, CMAX);

      // Protocol errors
      do_reset(); cycle();
      check("t6_clear", 32'(proto_err), 32'(0));
      grant = 4'b0011; cycle();
      cycle(); cycle();
      check("t6a_multi", 32'(proto_err), 32'(1));

      do_reset(); cycle();
      grant = 4'b1000; cycle();
      cycle(); cycle();
      check("t6b_idle", 32'(proto_err), 32'(1));

      do_reset(); cycle();
      job_push = 4'b0001; cycle();
      for (k = 0; k < 10 && !busy[0]; k++) cycle();
      check("t6c_busy", 32'(busy[0]), 32'(1));
      check("t6c_pre", 32'(proto_err), 32'(0));
      grant = '0; cycle();
      n_done = 0;
      for (int t = 0; t < 10; t++) begin
         cycle();
         if (done[0]) n_done++;
      end
      check("t6c_drop", 32'(proto_err), 32'(1));
      check("t6c_done", n_done, 1);
      do_reset(); cycle();
      check("t6c_cleared", 32'(proto_err), 32'(0));

      // Randomized traffic with occasional resets
      for (int t = 0; t < 500; t++) begin
         for (int c = 0; c < N; c++) job_push[c] = ($urandom_range(0, 5) == 0);
         rst = ($urandom_range(0, 149) != 0);
         cycle();
      end
      rst = 1'b1;
      for (int t = 0; t < 100; t++) cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
